// File: rtl/spi_inert_serf_pkg.sv
// Shared definitions for the inertial sensor model and its SPI serf: register map, reset values, FSM states.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package inert_pkg;

  // Register map (7-bit addresses)
  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL3_C   = 7'h14;
  localparam logic [6:0] ADDR_OUTZ_L_G  = 7'h26;
  localparam logic [6:0] ADDR_OUTZ_H_G  = 7'h27;

  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;

  // Init values the monarch must program before cfg_done is reported
  localparam logic [7:0] CFG_INT1_CTRL  = 8'h02;
  localparam logic [7:0] CFG_CTRL2_G    = 8'h60;
  localparam logic [7:0] CFG_CTRL3_C    = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

  // True for the two yaw output bytes, which must never be split across samples
  function automatic logic is_outz(input logic [6:0] addr);
    return (addr == ADDR_OUTZ_L_G) || (addr == ADDR_OUTZ_H_G);
  endfunction

endpackage

// File: rtl/spi_inert_serf_if.sv
// SPI bus between the monarch (master) and the sensor serf (slave).
// Latency: n/a (wires only).
// Backpressure: none; SPI is timed entirely by the monarch.
// Signals: SS_n select (active low), SCLK (idles high), MOSI, MISO; all MSB first.
interface spi_inert_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_inert_serf_shift.sv
// SPI serf front end: synchronizers, SCLK/SS_n edge detect, frame FSM, 16-bit shift register, bit counter.
// Latency: SPI pins to edge detect 3 clk; frame_vld_o pulses 1 clk after the 16th rising SCLK is seen.
// Backpressure: none; read data is taken combinationally from rd_dat_i on the 8th rising edge.
// Ports: clk/rst_n; ss_n_i/sclk_i/mosi_i raw pins; miso_o; cmd_addr_o/cmd_load_o (read-data load strobe);
//        data_phase_o/addr_o/rw_o (current frame); frame_vld_o/wr_dat_o (completed 16-bit frame).
module spi_serf_shift
  import inert_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic [7:0] rd_dat_i,
  output logic       miso_o,
  output logic [6:0] cmd_addr_o,
  output logic       cmd_load_o,
  output logic       data_phase_o,
  output logic [6:0] addr_o,
  output logic       rw_o,
  output logic       frame_vld_o,
  output logic [7:0] wr_dat_o
);

  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  spi_state_e  state_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] shift_q;
  logic        miso_q;
  logic        rw_q;
  logic [6:0]  addr_q;
  logic        frame_vld_q;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Two flops for metastability, a third only to form edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      ss_s1_q   <= ss_n_i;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      sclk_s1_q <= sclk_i;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= mosi_i;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;

  // Address as it stands once the 8th command bit is shifted in
  assign cmd_addr_o = {shift_q[5:0], mosi_s2_q};
  assign cmd_load_o = (state_q == ST_CMD) && sclk_rise && !ss_s2_q && (bit_cnt_q == 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 16'h0000;
      miso_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'h00;
      frame_vld_q <= 1'b0;
    end else begin
      frame_vld_q <= 1'b0;

      // MISO only moves on falling SCLK; zero during command bits and while deselected
      if (ss_s2_q) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        if (state_q == ST_DATA) begin
          miso_q <= shift_q[15];
        end else if (state_q == ST_CMD) begin
          miso_q <= 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 4'd0;
            shift_q   <= 16'h0000;
          end
        end
        ST_CMD: begin
          if (ss_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
          end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= ST_DATA;
              rw_q    <= shift_q[6];
              addr_q  <= cmd_addr_o;
              // Low byte restarts at zero so it ends up holding exactly the write data
              shift_q <= {(shift_q[6] ? rd_dat_i : 8'h00), 8'h00};
            end else begin
              shift_q <= {shift_q[14:0], mosi_s2_q};
            end
          end
        end
        ST_DATA: begin
          if (ss_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
          end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            shift_q   <= {shift_q[14:0], mosi_s2_q};
            if (bit_cnt_q == 4'd15) begin
              state_q     <= ST_DONE;
              frame_vld_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Surplus SCLK edges are ignored until deselect
          if (ss_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso_o       = miso_q;
  assign data_phase_o = (state_q == ST_DATA);
  assign addr_o       = addr_q;
  assign rw_o         = rw_q;
  assign frame_vld_o  = frame_vld_q;
  assign wr_dat_o     = shift_q[7:0];

endmodule

// File: rtl/spi_inert_serf.sv
// Inertial sensor SPI serf: register file, yaw sample timer and INT flag behind an SPI slave.
// Latency: write commits 1 clk after frame_vld; INT rises 1 clk after a period wrap (later if deferred).
// Backpressure: none; samples landing during a yaw-byte read are held until that frame ends.
// Ports: clk, rst_n; spi (slave modport: SS_n, SCLK, MOSI, MISO); INT; yaw_src[15:0]; cfg_done.
module spi_inert_serf
  import inert_pkg::*;
#(
  parameter logic [15:0] INT_PERIOD = 16'd2048,
  parameter bit          FAST_SIM   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_inert_serf_if.slave  spi,
  output logic             INT,
  input  logic [15:0]      yaw_src,
  output logic             cfg_done
);

  localparam logic [15:0] PERIOD     = FAST_SIM ? (INT_PERIOD >> 3) : INT_PERIOD;
  localparam logic [15:0] PERIOD_MAX = PERIOD - 16'd1;

  logic       miso;
  logic [6:0] cmd_addr;
  logic       cmd_load;
  logic       data_phase;
  logic [6:0] addr;
  logic       rw;
  logic       frame_vld;
  logic [7:0] wr_dat;
  logic [7:0] rd_dat;

  logic [7:0]  int1_q, int1_d;
  logic [7:0]  ctrl2_q, ctrl2_d;
  logic [7:0]  ctrl3_q, ctrl3_d;
  logic [7:0]  outz_l_q, outz_l_d;
  logic [7:0]  outz_h_q, outz_h_d;
  logic [15:0] per_q, per_d;
  logic        int_q, int_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_dat_q, pend_dat_d;

  logic        sample_ok;
  logic        busy;
  logic        latch;
  logic [15:0] latch_dat;

  spi_serf_shift u_shift (
    .clk          (clk),
    .rst_n        (rst_n),
    .ss_n_i       (spi.SS_n),
    .sclk_i       (spi.SCLK),
    .mosi_i       (spi.MOSI),
    .rd_dat_i     (rd_dat),
    .miso_o       (miso),
    .cmd_addr_o   (cmd_addr),
    .cmd_load_o   (cmd_load),
    .data_phase_o (data_phase),
    .addr_o       (addr),
    .rw_o         (rw),
    .frame_vld_o  (frame_vld),
    .wr_dat_o     (wr_dat)
  );

  assign spi.MISO = miso;

  always_comb begin
    rd_dat = 8'h00;
    case (cmd_addr)
      ADDR_INT1_CTRL: rd_dat = int1_q;
      ADDR_WHO_AM_I:  rd_dat = WHO_AM_I_VAL;
      ADDR_CTRL2_G:   rd_dat = ctrl2_q;
      ADDR_CTRL3_C:   rd_dat = ctrl3_q;
      ADDR_OUTZ_L_G:  rd_dat = outz_l_q;
      ADDR_OUTZ_H_G:  rd_dat = outz_h_q;
      default:        rd_dat = 8'h00;
    endcase
  end

  always_comb begin
    int1_d     = int1_q;
    ctrl2_d    = ctrl2_q;
    ctrl3_d    = ctrl3_q;
    outz_l_d   = outz_l_q;
    outz_h_d   = outz_h_q;
    per_d      = per_q;
    int_d      = int_q;
    pend_d     = pend_q;
    pend_dat_d = pend_dat_q;
    sample_ok  = 1'b0;
    latch      = 1'b0;
    latch_dat  = yaw_src;

    if (frame_vld && !rw) begin
      case (addr)
        ADDR_INT1_CTRL: int1_d  = wr_dat;
        ADDR_CTRL2_G:   ctrl2_d = wr_dat;
        ADDR_CTRL3_C:   ctrl3_d = wr_dat;
        default: ;
      endcase
    end

    // Period timer runs only while the gyro is enabled and is parked at 0 otherwise
    if (ctrl2_q == 8'h00) begin
      per_d = 16'h0000;
    end else if (per_q == PERIOD_MAX) begin
      per_d     = 16'h0000;
      sample_ok = int1_q[1];
    end else begin
      per_d = per_q + 16'd1;
    end

    // Yaw bytes are frozen from the read-data load until the frame completes or aborts
    busy = (data_phase && is_outz(addr)) || (cmd_load && is_outz(cmd_addr));

    if (sample_ok && busy) begin
      pend_d     = 1'b1;
      pend_dat_d = yaw_src;
    end else if ((sample_ok || pend_q) && !busy) begin
      latch     = 1'b1;
      latch_dat = sample_ok ? yaw_src : pend_dat_q;
      pend_d    = 1'b0;
    end

    if (latch) begin
      outz_l_d = latch_dat[7:0];
      outz_h_d = latch_dat[15:8];
    end

    // A fresh sample wins over the clearing read so it is never lost
    if (latch) begin
      int_d = 1'b1;
    end else if (frame_vld && rw && (addr == ADDR_OUTZ_H_G)) begin
      int_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_q     <= 8'h00;
      ctrl2_q    <= 8'h00;
      ctrl3_q    <= 8'h00;
      outz_l_q   <= 8'h00;
      outz_h_q   <= 8'h00;
      per_q      <= 16'h0000;
      int_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_dat_q <= 16'h0000;
    end else begin
      int1_q     <= int1_d;
      ctrl2_q    <= ctrl2_d;
      ctrl3_q    <= ctrl3_d;
      outz_l_q   <= outz_l_d;
      outz_h_q   <= outz_h_d;
      per_q      <= per_d;
      int_q      <= int_d;
      pend_q     <= pend_d;
      pend_dat_q <= pend_dat_d;
    end
  end

  assign INT      = int_q;
  assign cfg_done = (int1_q == CFG_INT1_CTRL) && (ctrl2_q == CFG_CTRL2_G) && (ctrl3_q == CFG_CTRL3_C);

endmodule

// File: tb/tb_spi_inert_serf.sv
// Directed bench for spi_inert_serf: SPI monarch tasks, register map, sample timing, deferral, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_inert_serf;

  localparam int PH  = 6;    // clk cycles per SCLK phase
  localparam int PER = 512;  // 4096 / 8 with FAST_SIM

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] yaw_src;
  logic        int_o;
  logic        cfg_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_inert_serf_if sif ();

  spi_inert_serf #(
    .INT_PERIOD (16'd4096),
    .FAST_SIM   (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (sif.slave),
    .INT      (int_o),
    .yaw_src  (yaw_src),
    .cfg_done (cfg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-3 style: drive MOSI on falling SCLK, sample MISO just before rising SCLK
  task automatic spi_frame(input logic [15:0] tx, input int nbits, input bit keep_sel,
                           output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge clk);
    sif.SS_n = 1'b0;
    clks(PH);
    for (int i = 15; i > 15 - nbits; i--) begin
      sif.SCLK = 1'b0;
      sif.MOSI = tx[i];
      clks(PH);
      rx[i] = sif.MISO;
      sif.SCLK = 1'b1;
      clks(PH);
    end
    if (!keep_sel) begin
      sif.SS_n = 1'b1;
      clks(PH + 2);
    end
  endtask

  task automatic wr(input logic [15:0] tx);
    logic [15:0] r;
    spi_frame(tx, 16, 1'b0, r);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] tx, input logic [7:0] exp);
    logic [15:0] r;
    spi_frame(tx, 16, 1'b0, r);
    chk(tag, {24'h0, r[7:0]}, {24'h0, exp});
  endtask

  task automatic wait_int(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (int_o === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] r;
    int t1, t2;
    bit ok;

    sif.SS_n = 1'b1;
    sif.SCLK = 1'b1;
    sif.MOSI = 1'b0;
    yaw_src  = 16'hF123;
    rst_n    = 1'b0;
    clks(4);
    chk("rst_miso", {31'h0, sif.MISO}, 32'h0);
    chk("rst_int", {31'h0, int_o}, 32'h0);
    chk("rst_cfg_done", {31'h0, cfg_done}, 32'h0);
    rst_n = 1'b1;
    clks(4);

    // WHO_AM_I: command byte returns zeros, data byte returns 6A
    spi_frame(16'h8F00, 16, 1'b0, r);
    chk("whoami_frame", {16'h0, r}, 32'h0000_006A);
    chk("miso_deselected", {31'h0, sif.MISO}, 32'h0);
    rd_chk("int1_after_rst", 16'h8D00, 8'h00);

    // Aborted write after 10 bits leaves INT1_CTRL alone
    spi_frame(16'h0D55, 10, 1'b0, r);
    rd_chk("abort_no_write", 16'h8D00, 8'h00);

    wr(16'h0D02);
    chk("cfg_done_partial1", {31'h0, cfg_done}, 32'h0);
    rd_chk("int1_readback", 16'h8D00, 8'h02);

    // Read-only and unmapped writes are ignored
    wr(16'h0F55);
    rd_chk("whoami_ro", 16'h8F00, 8'h6A);
    wr(16'h2655);
    rd_chk("outz_l_ro", 16'hA600, 8'h00);
    wr(16'h3055);
    rd_chk("unmapped", 16'hB000, 8'h00);

    // Abort during the data byte
    spi_frame(16'h0DAA, 12, 1'b0, r);
    rd_chk("abort_in_data", 16'h8D00, 8'h02);

    wr(16'h1160);
    chk("cfg_done_partial2", {31'h0, cfg_done}, 32'h0);
    wr(16'h1440);
    chk("cfg_done_set", {31'h0, cfg_done}, 32'h1);
    chk("int_before_period", {31'h0, int_o}, 32'h0);
    rd_chk("ctrl2_readback", 16'h9100, 8'h60);

    // First sample
    wait_int(1000, t1, ok);
    chk("int_rise1", {31'h0, ok}, 32'h1);
    rd_chk("outz_l_first", 16'hA600, 8'h23);
    chk("int_held_after_l", {31'h0, int_o}, 32'h1);
    rd_chk("outz_h_first", 16'hA700, 8'hF1);
    chk("int_cleared", {31'h0, int_o}, 32'h0);

    // Second sample one period after the first
    yaw_src = 16'h1234;
    wait_int(1000, t2, ok);
    chk("int_rise2", {31'h0, ok}, 32'h1);
    chk("sample_period", t2 - t1, PER);

    // Next wrap lands inside the data byte of an OUTZ_H read
    yaw_src = 16'h5678;
    while (cyc < t2 + PER - 150) @(negedge clk);
    rd_chk("deferred_old_hi", 16'hA700, 8'h12);
    chk("int_stays_high", {31'h0, int_o}, 32'h1);
    rd_chk("deferred_new_hi", 16'hA700, 8'h56);
    chk("int_cleared2", {31'h0, int_o}, 32'h0);
    rd_chk("deferred_new_lo", 16'hA600, 8'h78);
    rd_chk("ctrl3_readback", 16'h9400, 8'h40);

    // Reset in the middle of a WHO_AM_I data byte (MISO is 1 at that point)
    spi_frame(16'h8F00, 13, 1'b1, r);
    rst_n = 1'b0;
    clks(2);
    chk("midrst_miso", {31'h0, sif.MISO}, 32'h0);
    chk("midrst_int", {31'h0, int_o}, 32'h0);
    chk("midrst_cfg_done", {31'h0, cfg_done}, 32'h0);
    sif.SS_n = 1'b1;
    sif.SCLK = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(4);
    rd_chk("post_rst_whoami", 16'h8F00, 8'h6A);
    rd_chk("post_rst_ctrl2", 16'h9100, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_inert_serf.md
SPI_INERT_SERF -- requirements
Module: spi_inert_serf

Interface
REQ-001 Parameter INT_PERIOD, default 16'd2048: clk cycles between yaw samples once the sensor is enabled.
REQ-002 Parameter FAST_SIM, default 1: when 1, the effective sample period is INT_PERIOD/8.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- SS_n, in, 1, SPI select from the monarch, active low.
- SCLK, in, 1, SPI clock from the monarch; idles high.
- MOSI, in, 1, SPI data from the monarch, MSB first.
- MISO, out, 1, SPI data to the monarch, MSB first.
- INT, out, 1, high while a new yaw sample is unread.
- yaw_src, in, 16, signed yaw rate supplied by the bench or model.
- cfg_done, out, 1, high once all three init registers hold their required values.

Function
REQ-004 SS_n, SCLK and MOSI shall each be double-flopped into clk; all SPI edge detection shall use the synchronized copies. The monarch guarantees each SCLK phase lasts at least 4 clk cycles.
REQ-005 Frame format: 16 bits.
- bit15 = R/W (1 = read).
- bits14:8 = address.
- bits7:0 = write data; don't-care on a read.
REQ-006 MOSI shall be sampled on each rising SCLK edge while SS_n is low.
REQ-007 MISO shall change only on falling SCLK edges, driven from shift-register bit 15.
REQ-008 FSM states:
- IDLE: exit to CMD on SS_n falling.
- CMD: bits 0-7; exit to DATA after the 8th rising edge.
- DATA: bits 8-15; exit to DONE after the 16th rising edge.
- DONE: exit to IDLE on SS_n rising.
REQ-009 A 4-bit bit counter shall count rising SCLK edges and clear on SS_n falling.
REQ-010 On the 8th rising edge of a read, the addressed register value shall be loaded into shift[15:8]. MISO shall then present that byte on the following 8 falling edges.
REQ-011 During CMD, MISO shall output 0.
REQ-012 While SS_n is high, MISO shall be 0.
REQ-013 A write shall commit to the register file on the 16th rising edge, not before.
REQ-014 Registers:
- 0x0D INT1_CTRL, read/write.
- 0x11 CTRL2_G, read/write.
- 0x14 CTRL3_C, read/write.
- 0x26 OUTZ_L_G, read-only.
- 0x27 OUTZ_H_G, read-only.
- 0x0F WHO_AM_I, read-only, returns 8'h6A.
- Any other address reads 8'h00; writes to it are ignored.
REQ-015 Writes to read-only addresses shall be ignored.
REQ-016 cfg_done shall be high exactly while INT1_CTRL==8'h02, CTRL2_G==8'h60 and CTRL3_C==8'h40.
REQ-017 The sensor is enabled when CTRL2_G != 0. While enabled, a 16-bit period counter shall wrap at the effective period.
REQ-018 On each wrap, the sensor shall latch yaw_src into OUTZ_H_G/OUTZ_L_G and set INT, but only if INT1_CTRL[1]==1.
REQ-019 While a frame addressing 0x26 or 0x27 is in progress, latching shall be deferred until that frame ends. Bytes of one sample shall never be split.
REQ-020 INT shall clear on the clk after the 16th rising edge of a read of 0x27.
REQ-021 If a wrap and an INT-clearing read coincide, INT shall end high with the new data.
REQ-022 SS_n rising before 16 rising edges shall abort the frame: no write, FSM to IDLE, counter cleared.
REQ-023 SCLK edges after the 16th and before SS_n rises shall be ignored.
REQ-024 Writing CTRL2_G to 0 shall stop the period counter and clear it to 0; INT shall hold its current value.

Reset
REQ-025 On rst_n low, all of the following shall clear asynchronously:
- FSM to IDLE; bit counter, shift register and period counter to 0.
- All read/write registers and OUTZ registers to 8'h00.
- INT, MISO and cfg_done to 0.
- Synchronizer flops for SS_n and SCLK to 1; MOSI synchronizer to 0.
REQ-026 Reset asserted mid-frame shall discard the frame. After release, the block shall wait for the next SS_n falling edge.

Structure
REQ-027 Register address localparams, WHO_AM_I value and the FSM state enum shall live in a shared package inert_pkg, imported by this block and by the inertial interface block.
REQ-028 The SPI shift/edge logic shall be a sub-module spi_serf_shift (synchronizers, edge detect, shift register, bit counter).
REQ-029 The register file, period timer and INT logic shall reside in the top level.

Verification
REQ-030 Scenario: frame 16'h8F00 -> MISO byte during DATA = 8'h6A; no register changes.
REQ-031 Scenario: writes 0D02, 1160, 1440 -> cfg_done rises on the clk after the third frame's 16th edge; readback of 0x91xx returns 8'h60.
REQ-032 Scenario: config done, yaw_src=16'hF123 -> INT rises after INT_PERIOD/8 cycles; read A600 returns 8'h23; read A700 returns 8'hF1; INT falls after the A700 frame.
REQ-033 Scenario: SS_n raised after 10 bits of 16'h0D55 -> INT1_CTRL unchanged; next full frame decodes correctly.
REQ-034 Scenario: period wrap in the middle of an A700 read -> the returned byte is from the old sample; new sample is latched at frame end; INT stays high.
REQ-035 Scenario: rst_n pulsed during the DATA phase -> all outputs 0, cfg_done 0; a subsequent 8F00 read returns 8'h6A.
